// File: rtl/m68k_io_port_if.sv
// Bus bundle between the 68008 pins, the RAM port and the display path.
// The slave modport is the I/O port block and the master modport is the CPU/RAM side.
interface m68k_io_port_if #(
    parameter int ADDRLEN = 20
) ();
    // CPU side
    logic [ADDRLEN-1:0] addr_bus;
    logic [7:0]         data_in;
    logic               rw_;
    logic               as_;
    logic               ds_;
    logic [7:0]         data_out;
    logic               data_oe;
    logic               dtack_;
    // Synchronous RAM side
    logic [15:0]        mem_addr;
    logic               mem_we;
    logic               mem_re;
    logic [7:0]         mem_wdata;
    logic [7:0]         mem_rdata;
    // Display path
    logic [31:0]        display_value;
    logic               update;

    modport slave (
        input  addr_bus, data_in, rw_, as_, ds_, mem_rdata,
        output data_out, data_oe, dtack_, mem_addr, mem_we, mem_re, mem_wdata,
        output display_value, update
    );

    modport master (
        output addr_bus, data_in, rw_, as_, ds_, mem_rdata,
        input  data_out, data_oe, dtack_, mem_addr, mem_we, mem_re, mem_wdata,
        input  display_value, update
    );
endinterface

// File: rtl/m68k_io_port.sv
// 68008 bus slave. It synchronises the CPU strobes and serves a 4-byte display window.
// All other accesses go to a synchronous RAM port.
// A write to window byte 3 commits the 32-bit display word and pulses update.
module m68k_io_port #(
    parameter int                 ADDRLEN     = 20,
    parameter logic [ADDRLEN-1:0] IO_BASE     = 20'h81234,
    parameter int                 SYNC_STAGES = 2,
    parameter logic [15:0]        WP_LIMIT    = 16'h0100
) (
    input  logic           clk,
    input  logic           rst_n,
    m68k_io_port_if.slave  bus
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_DECODE, ST_MEM_WAIT, ST_ACK, ST_RELEASE
    } state_t;

    state_t                 state_reg;
    logic [SYNC_STAGES-1:0] as_sync_reg, ds_sync_reg, rw_sync_reg, fill_reg;
    logic                   armed_reg;
    logic [ADDRLEN-1:0]     addr_latch_reg;
    logic [7:0]             data_latch_reg;
    logic                   rw_latch_reg;
    logic [7:0]             shadow0_reg, shadow1_reg, shadow2_reg;
    logic [7:0]             data_out_reg, mem_wdata_reg;
    logic [15:0]            mem_addr_reg;
    logic                   mem_we_reg, mem_re_reg, update_reg;
    logic [31:0]            display_reg;

    logic as_s, ds_s, rw_s, hit_in, hit_latch;
    logic [1:0] byte_idx;

    assign as_s      = as_sync_reg[SYNC_STAGES-1];
    assign ds_s      = ds_sync_reg[SYNC_STAGES-1];
    assign rw_s      = rw_sync_reg[SYNC_STAGES-1];
    assign hit_in    = (bus.addr_bus[ADDRLEN-1:2] == IO_BASE[ADDRLEN-1:2]);
    assign hit_latch = (addr_latch_reg[ADDRLEN-1:2] == IO_BASE[ADDRLEN-1:2]);
    assign byte_idx  = addr_latch_reg[1:0];

    // Strobe synchronisers. fill_reg marks when the chains hold real pin samples after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            as_sync_reg <= '1;
            ds_sync_reg <= '1;
            rw_sync_reg <= '1;
            fill_reg    <= '0;
        end else begin
            as_sync_reg <= {as_sync_reg[SYNC_STAGES-2:0], bus.as_};
            ds_sync_reg <= {ds_sync_reg[SYNC_STAGES-2:0], bus.ds_};
            rw_sync_reg <= {rw_sync_reg[SYNC_STAGES-2:0], bus.rw_};
            fill_reg    <= {fill_reg[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Bus-cycle FSM with registered side effects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            armed_reg      <= 1'b0;
            addr_latch_reg <= '0;
            data_latch_reg <= '0;
            rw_latch_reg   <= 1'b0;
            shadow0_reg    <= '0;
            shadow1_reg    <= '0;
            shadow2_reg    <= '0;
            data_out_reg   <= '0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            mem_we_reg     <= 1'b0;
            mem_re_reg     <= 1'b0;
            update_reg     <= 1'b0;
            display_reg    <= '0;
        end else begin
            mem_we_reg <= 1'b0;
            mem_re_reg <= 1'b0;
            update_reg <= 1'b0;
            // A cycle already running when reset was released is ignored.
            // New cycles are accepted only after AS has been seen high.
            if (fill_reg[SYNC_STAGES-1] && as_s)
                armed_reg <= 1'b1;

            case (state_reg)
                ST_IDLE: begin
                    if (armed_reg && !as_s && !ds_s) begin
                        addr_latch_reg <= bus.addr_bus;
                        data_latch_reg <= bus.data_in;
                        rw_latch_reg   <= rw_s;
                        // The RAM strobe is issued on the DECODE entry edge.
                        // Read data from the synchronous RAM is then present during MEM_WAIT.
                        if (!hit_in) begin
                            mem_addr_reg <= bus.addr_bus[15:0];
                            if (rw_s) begin
                                mem_re_reg <= 1'b1;
                            end else begin
                                mem_wdata_reg <= bus.data_in;
                                mem_we_reg    <= (bus.addr_bus[15:0] >= WP_LIMIT);
                            end
                        end
                        state_reg <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (hit_latch && rw_latch_reg) begin
                        case (byte_idx)
                            2'd0:    data_out_reg <= display_reg[31:24];
                            2'd1:    data_out_reg <= display_reg[23:16];
                            2'd2:    data_out_reg <= display_reg[15:8];
                            default: data_out_reg <= display_reg[7:0];
                        endcase
                    end else if (hit_latch) begin
                        case (byte_idx)
                            2'd0:    shadow0_reg <= data_latch_reg;
                            2'd1:    shadow1_reg <= data_latch_reg;
                            2'd2:    shadow2_reg <= data_latch_reg;
                            default: begin
                                display_reg <= {shadow0_reg, shadow1_reg, shadow2_reg, data_latch_reg};
                                update_reg  <= 1'b1;
                            end
                        endcase
                    end
                    if (ds_s)
                        state_reg <= ST_RELEASE;
                    else if (!hit_latch && rw_latch_reg)
                        state_reg <= ST_MEM_WAIT;
                    else
                        state_reg <= ST_ACK;
                end
                ST_MEM_WAIT: begin
                    data_out_reg <= bus.mem_rdata;
                    state_reg    <= ds_s ? ST_RELEASE : ST_ACK;
                end
                ST_ACK: begin
                    if (ds_s)
                        state_reg <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (ds_s && as_s)
                        state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // DTACK and the data-bus enable come straight from the state register.
    // A reset therefore releases them without waiting for a clock edge.
    assign bus.dtack_        = ~(state_reg == ST_ACK);
    assign bus.data_oe       = (state_reg == ST_ACK) & rw_latch_reg;
    assign bus.data_out      = data_out_reg;
    assign bus.mem_addr      = mem_addr_reg;
    assign bus.mem_we        = mem_we_reg;
    assign bus.mem_re        = mem_re_reg;
    assign bus.mem_wdata     = mem_wdata_reg;
    assign bus.display_value = display_reg;
    assign bus.update        = update_reg;
endmodule

// File: tb/tb_m68k_io_port.sv
// Bench for m68k_io_port. It drives CPU bus cycles and models the synchronous RAM.
// Expected RAM writes, display commits and read data go into scoreboard queues.
// The queues are checked when the DUT produces the matching output.
module tb_m68k_io_port;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    m68k_io_port_if #(.ADDRLEN(20)) bus ();

    m68k_io_port #(
        .ADDRLEN(20), .IO_BASE(20'h81234), .SYNC_STAGES(2), .WP_LIMIT(16'h0100)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } mem_exp_t;

    mem_exp_t    mem_q[$];
    logic [7:0]  rd_q[$];
    logic [31:0] disp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] ram [0:65535];
    logic prev_update = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Synchronous RAM model. Read data appears the cycle after mem_re.
    always @(posedge clk) begin
        if (!rst_n)
            bus.mem_rdata <= 8'h00;
        else begin
            if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr];
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    // Output monitor: compares RAM write strobes and display commits against the scoreboard.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (bus.mem_we) begin
                if (mem_q.size() == 0)
                    check_val("mem_we_unexpected", 32'd1, 32'd0);
                else begin
                    mem_exp_t e;
                    e = mem_q.pop_front();
                    check_val("mem_addr", {16'h0, bus.mem_addr}, {16'h0, e.addr});
                    check_val("mem_wdata", {24'h0, bus.mem_wdata}, {24'h0, e.data});
                end
            end
            if (bus.update) begin
                if (prev_update)
                    check_val("update_width", 32'd2, 32'd1);
                if (disp_q.size() == 0)
                    check_val("update_unexpected", 32'd1, 32'd0);
                else
                    check_val("display_value", bus.display_value, disp_q.pop_front());
            end
        end
        prev_update = bus.update;
    end

    // One full bus cycle: assert strobes, await DTACK, check latency and data, release.
    task automatic bus_cycle(input string tag, input bit is_read, input logic [19:0] a,
                             input logic [7:0] d, input int exp_lat);
        bit hit, seen;
        int lat;
        logic [7:0] exp_rd;
        hit = (a[19:2] == 18'h2048D);
        exp_rd = d;
        if (!is_read && !hit && a[15:0] >= 16'h0100) begin
            mem_exp_t e;
            e.addr = a[15:0];
            e.data = d;
            mem_q.push_back(e);
        end
        if (is_read) rd_q.push_back(d);
        @(negedge clk);
        bus.addr_bus = a; bus.data_in = d; bus.rw_ = is_read;
        bus.as_ = 1'b0; bus.ds_ = 1'b0;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge clk); #1; lat++;
            if (!bus.dtack_) seen = 1'b1;
        end
        check_val({tag, "_ack"}, {31'h0, seen}, 32'd1);
        if (seen) begin
            check_val({tag, "_lat"}, lat, exp_lat);
            check_val({tag, "_oe"}, {31'h0, bus.data_oe}, {31'h0, is_read});
            check_val({tag, "_upd"}, {31'h0, bus.update},
                      {31'h0, (hit && !is_read && a[1:0] == 2'd3)});
            if (is_read && rd_q.size() > 0) begin
                exp_rd = rd_q.pop_front();
                check_val({tag, "_data"}, {24'h0, bus.data_out}, {24'h0, exp_rd});
            end
        end
        @(negedge clk);
        bus.as_ = 1'b1; bus.ds_ = 1'b1;
        lat = 0;
        while (!bus.dtack_ && lat < 10) begin
            @(posedge clk); #1; lat++;
        end
        check_val({tag, "_rel"}, {30'h0, bus.dtack_, bus.data_oe}, 32'd2);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        bit ack_seen;
        bus.addr_bus = '0; bus.data_in = '0; bus.rw_ = 1'b1;
        bus.as_ = 1'b0; bus.ds_ = 1'b0;

        // Reset held with the strobes low
        repeat (5) @(negedge clk);
        check_val("rst_dtack", {31'h0, bus.dtack_}, 32'd1);
        check_val("rst_oe", {31'h0, bus.data_oe}, 32'd0);
        check_val("rst_display", bus.display_value, 32'h0);
        check_val("rst_pulses", {29'h0, bus.update, bus.mem_we, bus.mem_re}, 32'd0);
        rst_n = 1'b1;
        ack_seen = 1'b0;
        repeat (10) begin @(posedge clk); #1; if (!bus.dtack_) ack_seen = 1'b1; end
        check_val("rst_no_ack", {31'h0, ack_seen}, 32'd0);
        @(negedge clk); bus.as_ = 1'b1; bus.ds_ = 1'b1;
        repeat (4) @(negedge clk);

        // Window commit, readback, partial update
        bus_cycle("wr_b0", 1'b0, 20'h81234, 8'h12, 4);
        bus_cycle("wr_b1", 1'b0, 20'h81235, 8'h34, 4);
        bus_cycle("wr_b2", 1'b0, 20'h81236, 8'h56, 4);
        check_val("partial_display", bus.display_value, 32'h0);
        disp_q.push_back(32'h12345678);
        bus_cycle("wr_b3", 1'b0, 20'h81237, 8'h78, 4);
        check_val("commit_display", bus.display_value, 32'h12345678);
        bus_cycle("rd_b1", 1'b1, 20'h81235, 8'h34, 4);
        bus_cycle("rd_b0", 1'b1, 20'h81234, 8'h12, 4);
        bus_cycle("rd_b3", 1'b1, 20'h81237, 8'h78, 4);
        bus_cycle("wr_b0_again", 1'b0, 20'h81234, 8'hFF, 4);
        check_val("partial_keep", bus.display_value, 32'h12345678);
        bus_cycle("rd_committed", 1'b1, 20'h81234, 8'h12, 4);

        // RAM path and write protect boundary
        bus_cycle("ram_wr", 1'b0, 20'h00200, 8'hA5, 4);
        bus_cycle("ram_rd", 1'b1, 20'h00200, 8'hA5, 5);
        bus_cycle("wp_wr", 1'b0, 20'h000FF, 8'h11, 4);
        bus_cycle("wp_edge_wr", 1'b0, 20'h00100, 8'h22, 4);
        bus_cycle("wp_edge_rd", 1'b1, 20'h00100, 8'h22, 5);
        bus_cycle("alias_wr", 1'b0, 20'h01234, 8'h5A, 4);
        bus_cycle("alias_rd", 1'b1, 20'h01234, 8'h5A, 5);

        // Abort: DS rises while the RAM read is still in DECODE/MEM_WAIT
        @(negedge clk);
        bus.addr_bus = 20'h00200; bus.rw_ = 1'b1; bus.as_ = 1'b0; bus.ds_ = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk); bus.ds_ = 1'b1;
        ack_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (!bus.dtack_ || bus.data_oe) ack_seen = 1'b1;
            if (i == 3) begin @(negedge clk); bus.as_ = 1'b1; end
        end
        check_val("abort_no_ack", {31'h0, ack_seen}, 32'd0);
        bus_cycle("after_abort", 1'b1, 20'h00200, 8'hA5, 5);

        // Reset in the middle of a window write
        @(negedge clk);
        bus.addr_bus = 20'h81235; bus.data_in = 8'hBB; bus.rw_ = 1'b0;
        bus.as_ = 1'b0; bus.ds_ = 1'b0;
        repeat (4) @(posedge clk);
        #1 check_val("mid_pre_ack", {31'h0, bus.dtack_}, 32'd0);
        #3 rst_n = 1'b0;
        #1;
        check_val("mid_rst_dtack", {31'h0, bus.dtack_}, 32'd1);
        check_val("mid_rst_oe", {31'h0, bus.data_oe}, 32'd0);
        check_val("mid_rst_display", bus.display_value, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ack_seen = 1'b0;
        repeat (8) begin @(posedge clk); #1; if (!bus.dtack_) ack_seen = 1'b1; end
        check_val("mid_rst_ignored", {31'h0, ack_seen}, 32'd0);
        @(negedge clk); bus.as_ = 1'b1; bus.ds_ = 1'b1;
        repeat (5) @(negedge clk);
        disp_q.push_back(32'h00000099);
        bus_cycle("shadow_cleared", 1'b0, 20'h81237, 8'h99, 4);
        check_val("shadow_cleared_display", bus.display_value, 32'h00000099);

        // Drain checks
        repeat (3) @(negedge clk);
        check_val("mem_q_empty", mem_q.size(), 32'd0);
        check_val("disp_q_empty", disp_q.size(), 32'd0);
        check_val("rd_q_empty", rd_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
